// File: rtl/matmul_host_sequencer_pkg.sv
// matmul_host_sequencer_pkg: shared state encoding and default widths for the matmul host sequencer.
package matmul_host_sequencer_pkg;
  localparam int DWIDTH_DEF  = 16;
  localparam int BB_SIZE_DEF = 4;
  localparam int AWIDTH_DEF  = 7;
  localparam int WORD_W      = DWIDTH_DEF * BB_SIZE_DEF;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, READ_C, RD_DRAIN} state_t;
endpackage

// File: rtl/matmul_host_sequencer_delay_line.sv
// seq_delay_line: DEPTH-stage shift register; o_q is i_d delayed by exactly DEPTH cycles.
module seq_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [DEPTH-1:0][WIDTH-1:0] r_sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sr <= '0;
    else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/matmul_host_sequencer.sv
// matmul_host_sequencer: loads A/B words into the matmul wrapper BRAMs, runs the multiply, streams C back.
// Define MATMUL_SEQ_TIMEOUT_EN to add a COMPUTE watchdog and the timeout_err output.
module matmul_host_sequencer
  import matmul_host_sequencer_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int BB_SIZE        = BB_SIZE_DEF,
  parameter int AWIDTH         = AWIDTH_DEF,
  parameter int A_WORDS        = 8,
  parameter int B_WORDS        = 8,
  parameter int C_WORDS        = 8,
  parameter int WR_ADDR_LAG    = 2,
  parameter int RD_LATENCY     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int W             = BB_SIZE * DWIDTH
) (
  input  logic              clk,
  input  logic              reset_0,
  input  logic              cmd_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic [W-1:0]      data_pi,
  output logic [AWIDTH-1:0] addr_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic              start_mat_mul_0,
  input  logic              done_mat_mul,
  input  logic [W-1:0]      data_from_out_mat,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              busy,
  output logic              job_done
`ifdef MATMUL_SEQ_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);
  state_t r_state, w_next;
  logic [AWIDTH-1:0] r_cnt, r_addr, r_ocnt;
  logic [W-1:0] r_out_data;
  logic r_out_valid, r_job_done;
  logic w_hs, w_issue, w_rd_tail, w_last_out, w_to;

  assign in_ready                = r_state == LOAD_A || r_state == LOAD_B;
  assign enable_writing_to_mem   = in_ready || r_state == WR_DRAIN;
  assign enable_reading_from_mem = r_state == READ_C || r_state == RD_DRAIN;
  assign start_mat_mul_0         = r_state == COMPUTE;
  assign we_c                    = r_state == COMPUTE;
  assign busy                    = r_state != IDLE;
  assign w_hs                    = in_valid && in_ready;
  assign w_issue                 = w_hs || r_state == READ_C;
  // addr_pi shows the live counter only while an address is being issued, otherwise it holds the last one
  assign addr_pi                 = w_issue ? r_cnt : r_addr;
  assign w_last_out              = w_rd_tail && r_ocnt == AWIDTH'(C_WORDS - 1);
  assign out_valid               = r_out_valid;
  assign out_data                = r_out_data;
  assign job_done                = r_job_done;

  seq_delay_line #(.DEPTH(WR_ADDR_LAG), .WIDTH(W + 2)) u_wr_lag (
    .clk (clk),
    .rst (reset_0),
    .i_d ({{W{w_hs}} & in_data, w_hs && r_state == LOAD_A, w_hs && r_state == LOAD_B}),
    .o_q ({data_pi, we_a, we_b})
  );

  seq_delay_line #(.DEPTH(RD_LATENCY), .WIDTH(1)) u_rd_valid (
    .clk (clk),
    .rst (reset_0),
    .i_d (r_state == READ_C),
    .o_q (w_rd_tail)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = cmd_start ? LOAD_A : IDLE;
      LOAD_A:   w_next = (w_hs && r_cnt == AWIDTH'(A_WORDS - 1)) ? LOAD_B : LOAD_A;
      LOAD_B:   w_next = (w_hs && r_cnt == AWIDTH'(B_WORDS - 1)) ? WR_DRAIN : LOAD_B;
      WR_DRAIN: w_next = r_cnt == AWIDTH'(WR_ADDR_LAG - 1) ? COMPUTE : WR_DRAIN;
      COMPUTE:  w_next = done_mat_mul ? READ_C : w_to ? IDLE : COMPUTE;
      READ_C:   w_next = r_cnt == AWIDTH'(C_WORDS - 1) ? RD_DRAIN : READ_C;
      RD_DRAIN: w_next = w_last_out ? IDLE : RD_DRAIN;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_0)
    if (reset_0) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_ocnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_job_done  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next != r_state) ? '0 : (w_issue || r_state == WR_DRAIN) ? r_cnt + AWIDTH'(1) : r_cnt;
      r_addr      <= w_issue ? r_cnt : r_addr;
      r_ocnt      <= w_last_out ? '0 : r_ocnt + AWIDTH'(w_rd_tail);
      r_out_valid <= w_rd_tail;
      r_out_data  <= w_rd_tail ? data_from_out_mat : r_out_data;
      r_job_done  <= w_last_out;
    end

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic r_timeout_err;
  assign w_to        = r_state == COMPUTE && r_tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err = r_timeout_err;
  always_ff @(posedge clk or posedge reset_0)
    if (reset_0) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tcnt        <= r_state == COMPUTE ? r_tcnt + TW'(1) : '0;
      r_timeout_err <= (r_state == IDLE && cmd_start) ? 1'b0 : (w_to && !done_mat_mul) ? 1'b1 : r_timeout_err;
    end
`else
  assign w_to = 1'b0;
`endif
endmodule

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
- Host-side control stage directly upstream of the 8x8 matmul wrapper; drives its data_pi/addr_pi/we_a/we_b/we_c/enable_* /start_mat_mul_0 pins and consumes done_mat_mul and data_from_out_mat.
- Accepts a valid/ready word stream: A words first, then B words. Writes them into the A/B BRAMs with the wrapper's address-lag alignment. Runs the multiply, then streams the C words back out with a fixed-latency capture.

Parameters:
- DWIDTH, 16, element width
- BB_SIZE, 4, elements per word; word width W = BB_SIZE*DWIDTH = 64
- AWIDTH, 7, BRAM address width
- A_WORDS, 8, words written to A (addresses 0..A_WORDS-1)
- B_WORDS, 8, words written to B
- C_WORDS, 8, words read from C
- WR_ADDR_LAG, 2, cycles between addr_pi and the matching data_pi/we
- RD_LATENCY, 8, cycles from addr_pi to valid data_from_out_mat
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- reset_0  in  1  async active-high reset
- cmd_start  in  1  one-cycle pulse; begins a job when idle
- in_valid  in  1  host word valid
- in_ready  out  1  sequencer accepts word
- in_data  in  W  host word (A then B)
- data_pi  out  W  to wrapper
- addr_pi  out  AWIDTH  to wrapper
- we_a, we_b, we_c  out  1 each  BRAM write enables
- enable_writing_to_mem  out  1  to wrapper
- enable_reading_from_mem  out  1  to wrapper
- start_mat_mul_0  out  1  to wrapper
- done_mat_mul  in  1  from wrapper
- data_from_out_mat  in  W  from wrapper
- out_valid  out  1  C word valid (no backpressure)
- out_data  out  W  C word
- busy  out  1  high in any non-IDLE state
- job_done  out  1  one-cycle pulse when the last C word has been emitted

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0. Asserting reset mid-job aborts immediately; there is no resume.
- FSM: IDLE -> LOAD_A -> LOAD_B -> WR_DRAIN -> COMPUTE -> READ_C -> RD_DRAIN -> IDLE.
- IDLE: cmd_start goes to LOAD_A. cmd_start in any other state is ignored.
- LOAD_A / LOAD_B:
  - in_ready=1; enable_writing_to_mem=1.
  - On each in_valid&&in_ready handshake at cycle t: addr_pi = word count (0-based, per matrix) at t. data_pi = that word at t+WR_ADDR_LAG. we_a (or we_b) = 1 at t+WR_ADDR_LAG only.
  - Implement the lag with a WR_ADDR_LAG-deep shift register of {data, we_a, we_b}.
  - Gaps in in_valid are allowed; addr_pi holds its last value.
  - Last A handshake goes to LOAD_B; last B handshake goes to WR_DRAIN.
- WR_DRAIN:
  - in_ready=0; enable_writing_to_mem stays 1 for WR_ADDR_LAG cycles so the delayed writes land.
  - Then enable_writing_to_mem=0 and go to COMPUTE.
- COMPUTE:
  - start_mat_mul_0=1 and we_c=1, both held as levels.
  - When done_mat_mul=1: both drop next cycle, go to READ_C.
  - done_mat_mul=1 on the first COMPUTE cycle is legal and is honoured.
- READ_C:
  - enable_reading_from_mem=1; addr_pi counts 0..C_WORDS-1, one per cycle; a 1 is pushed into a RD_LATENCY-deep valid shift register per address.
  - After the last address go to RD_DRAIN; enable_reading_from_mem stays 1 until the shift register empties.
- Read output: out_valid = shift-register tail; out_data = data_from_out_mat, registered alongside out_valid.
- RD_DRAIN: job_done pulses on the cycle the final out_valid is emitted; return to IDLE on the same edge.
- Width rules: word counters are AWIDTH bits; A_WORDS, B_WORDS, C_WORDS ≤ 2^AWIDTH. Counters never wrap within a job.
- Mutual exclusion: enable_writing_to_mem and enable_reading_from_mem are never high together; we_a and we_b are never high together.

Optional Feature:
- MATMUL_SEQ_TIMEOUT_EN defined:
  - Adds a cycle counter in COMPUTE plus an output port timeout_err (1 bit, reset 0).
  - If done_mat_mul is not seen within TIMEOUT_CYCLES: drop start_mat_mul_0/we_c, set timeout_err (sticky until the next cmd_start), return to IDLE without READ_C and without job_done.
- Undefined: no counter, no port; COMPUTE waits indefinitely.

Decomposition:
- Shared package: state enum (IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, READ_C, RD_DRAIN), the DWIDTH/AWIDTH/BB_SIZE defaults, and the word-width localparam.
- One sub-module: seq_delay_line (parameterised depth/width shift register with async reset). It is instantiated twice: the write-lag path and the read-valid path.

Test Plan:
- Reset mid-LOAD_B (after 3 B words) -> all outputs 0 next cycle; busy=0; new cmd_start then loads from address 0.
- cmd_start, 8 A words 0x1..0x8 back-to-back -> addr_pi 0..7 on cycles t..t+7; we_a with data 0x1..0x8 on cycles t+2..t+9; we_b never high.
- B load with in_valid toggling 1,0,1,0 -> addr_pi increments only on handshakes; each we_b lands exactly 2 cycles after its address; in_ready=0 in WR_DRAIN.
- done_mat_mul stubbed high 50 cycles after start -> start_mat_mul_0/we_c high exactly through the done cycle, low the next cycle; READ_C begins.
- C model returning word = addr+0x100 with 8-cycle latency -> out_valid for 8 consecutive cycles with 0x100..0x107; job_done coincides with 0x107.
- MATMUL_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> timeout_err=1 after 16 COMPUTE cycles; FSM in IDLE; no out_valid, no job_done.
